// File: rtl/array_access_arbiter.sv
// array_access_arbiter: two requesters share one small signed register array.
// Each requester owns a single slot (EMPTY -> PENDING -> RESPONDING). At most
// one PENDING slot is granted per edge, round-robin on contention, and the
// granted access executes against the array on that same edge.
module array_access_arbiter #(
    parameter int                         DEPTH     = 5,
    parameter int                         DATA_W    = 32,
    parameter logic signed [DATA_W-1:0]   ERR_VALUE = 32'hFFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   req0_addr,
    input  logic                         req0_we,
    input  logic signed [DATA_W-1:0]     req0_data,
    input  logic                         req0_sync,
    output logic                         req0_notify,
    output logic signed [DATA_W-1:0]     rsp0_out,
    output logic                         rsp0_err,
    input  logic                         rsp0_sync,
    output logic                         rsp0_notify,
    input  logic [2:0]                   req1_addr,
    input  logic                         req1_we,
    input  logic signed [DATA_W-1:0]     req1_data,
    input  logic                         req1_sync,
    output logic                         req1_notify,
    output logic signed [DATA_W-1:0]     rsp1_out,
    output logic                         rsp1_err,
    input  logic                         rsp1_sync,
    output logic                         rsp1_notify
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PENDING = 2'd1,
        S_RESP    = 2'd2
    } slot_e;

    slot_e                     slot_q [2];
    slot_e                     slot_d [2];
    logic [1:0]                req_sync_v;
    logic [1:0]                rsp_sync_v;
    logic [1:0]                req_notify_v;
    logic [1:0]                rsp_notify_v;

    logic [2:0]                cap_addr [2];
    logic                      cap_we   [2];
    logic signed [DATA_W-1:0]  cap_data [2];

    logic                      rr_q;
    logic signed [DATA_W-1:0]  mem_q [DEPTH];

    logic [1:0]                grant;
    logic                      gsel;
    logic [2:0]                g_addr;
    logic                      g_we;
    logic signed [DATA_W-1:0]  g_data;
    logic                      g_in_rng;
    logic signed [DATA_W-1:0]  g_rd;

    logic signed [DATA_W-1:0]  rsp_out_q [2];
    logic [1:0]                rsp_err_q;

    assign req_sync_v = {req1_sync, req0_sync};
    assign rsp_sync_v = {rsp1_sync, rsp0_sync};

    // Slot state registers; reset discards any pending or undelivered work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) slot_q[n] <= S_EMPTY;
        end else begin
            for (int n = 0; n < 2; n++) slot_q[n] <= slot_d[n];
        end
    end

    // Slot next-state: accept when empty, leave PENDING on grant, free on response transfer.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            slot_d[n] = slot_q[n];
            case (slot_q[n])
                S_EMPTY:   if (req_sync_v[n]) slot_d[n] = S_PENDING;
                S_PENDING: if (grant[n])      slot_d[n] = S_RESP;
                S_RESP:    if (rsp_sync_v[n]) slot_d[n] = S_EMPTY;
                default:                      slot_d[n] = S_EMPTY;
            endcase
        end
    end

    // Handshake outputs decode straight from the slot registers (no input path).
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            req_notify_v[n] = (slot_q[n] == S_EMPTY);
            rsp_notify_v[n] = (slot_q[n] == S_RESP);
        end
    end

    // Arbitration: a lone PENDING slot always wins; on contention rr picks the winner.
    always_comb begin
        grant[0] = (slot_q[0] == S_PENDING) && ((slot_q[1] != S_PENDING) || !rr_q);
        grant[1] = (slot_q[1] == S_PENDING) && ((slot_q[0] != S_PENDING) ||  rr_q);
        gsel     = grant[1];
        g_addr   = cap_addr[gsel];
        g_we     = cap_we[gsel];
        g_data   = cap_data[gsel];
        g_in_rng = ({29'd0, g_addr} < 32'(DEPTH));
        g_rd     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (g_addr == 3'(i)) g_rd = mem_q[i];
        end
    end

    // Request capture; only meaningful while the slot is PENDING, so no reset needed.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (slot_q[n] == S_EMPTY && req_sync_v[n]) begin
                cap_addr[n] <= (n == 0) ? req0_addr : req1_addr;
                cap_we[n]   <= (n == 0) ? req0_we   : req1_we;
                cap_data[n] <= (n == 0) ? req0_data : req1_data;
            end
        end
    end

    // Array storage and round-robin pointer; the pointer moves to the loser of each grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (|grant) begin
            rr_q <= ~gsel;
            if (g_we && g_in_rng) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (g_addr == 3'(i)) mem_q[i] <= g_data;
                end
            end
        end
    end

    // Response registers: loaded at the grant edge with the pre-write contents, then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) rsp_out_q[n] <= '0;
            rsp_err_q <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (grant[n]) begin
                    rsp_out_q[n] <= g_in_rng ? g_rd : ERR_VALUE;
                    rsp_err_q[n] <= !g_in_rng;
                end
            end
        end
    end

    assign req0_notify = req_notify_v[0];
    assign req1_notify = req_notify_v[1];
    assign rsp0_notify = rsp_notify_v[0];
    assign rsp1_notify = rsp_notify_v[1];
    assign rsp0_out    = rsp_out_q[0];
    assign rsp1_out    = rsp_out_q[1];
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_array_access_arbiter.sv
// Bench for array_access_arbiter: directed scenarios followed by a long random
// run, all checked against a transaction-rule model kept in the bench.
module tb_array_access_arbiter;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         a_addr [2];
    logic               a_we   [2];
    logic signed [31:0] a_data [2];
    logic               a_sync [2];
    logic               r_sync [2];

    logic               req0_notify, req1_notify, rsp0_notify, rsp1_notify;
    logic               rsp0_err, rsp1_err;
    logic signed [31:0] rsp0_out, rsp1_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (spec-level: slot phase, pointer, storage, responses)
    int          m_st   [2];   // 0 empty, 1 pending, 2 responding
    int          m_rr;
    logic [31:0] m_mem  [5];
    logic [31:0] m_out  [2];
    logic        m_err  [2];
    int          m_addr [2];
    bit          m_we   [2];
    logic [31:0] m_data [2];

    array_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_addr(a_addr[0]), .req0_we(a_we[0]), .req0_data(a_data[0]),
        .req0_sync(a_sync[0]), .req0_notify(req0_notify),
        .rsp0_out(rsp0_out), .rsp0_err(rsp0_err),
        .rsp0_sync(r_sync[0]), .rsp0_notify(rsp0_notify),
        .req1_addr(a_addr[1]), .req1_we(a_we[1]), .req1_data(a_data[1]),
        .req1_sync(a_sync[1]), .req1_notify(req1_notify),
        .rsp1_out(rsp1_out), .rsp1_err(rsp1_err),
        .rsp1_sync(r_sync[1]), .rsp1_notify(rsp1_notify)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_st[n] = 0; m_out[n] = '0; m_err[n] = 1'b0;
            m_addr[n] = 0; m_we[n] = 1'b0; m_data[n] = '0;
        end
        m_rr = 0;
        for (int i = 0; i < 5; i++) m_mem[i] = '0;
    endtask

    // Apply one clock edge's worth of transfers and at most one array access.
    task automatic model_edge();
        bit rq [2];
        bit rs [2];
        int g;
        for (int n = 0; n < 2; n++) begin
            rq[n] = a_sync[n] && (m_st[n] == 0);
            rs[n] = r_sync[n] && (m_st[n] == 2);
        end
        g = -1;
        if (m_st[0] == 1 && m_st[1] == 1) g = m_rr;
        else if (m_st[0] == 1)            g = 0;
        else if (m_st[1] == 1)            g = 1;
        if (g >= 0) begin
            if (m_addr[g] < 5) begin
                m_out[g] = m_mem[m_addr[g]];
                m_err[g] = 1'b0;
                if (m_we[g]) m_mem[m_addr[g]] = m_data[g];
            end else begin
                m_out[g] = 32'hFFFF_FFFF;
                m_err[g] = 1'b1;
            end
            m_st[g] = 2;
            m_rr    = 1 - g;
        end
        for (int n = 0; n < 2; n++) begin
            if (rs[n]) m_st[n] = 0;
            if (rq[n]) begin
                m_st[n]   = 1;
                m_addr[n] = int'(a_addr[n]);
                m_we[n]   = a_we[n];
                m_data[n] = a_data[n];
            end
        end
    endtask

    task automatic compare_all();
        check("req0_notify", 32'(req0_notify), 32'(m_st[0] == 0));
        check("req1_notify", 32'(req1_notify), 32'(m_st[1] == 0));
        check("rsp0_notify", 32'(rsp0_notify), 32'(m_st[0] == 2));
        check("rsp1_notify", 32'(rsp1_notify), 32'(m_st[1] == 2));
        check("rsp0_out",    rsp0_out,         m_out[0]);
        check("rsp1_out",    rsp1_out,         m_out[1]);
        check("rsp0_err",    32'(rsp0_err),    32'(m_err[0]));
        check("rsp1_err",    32'(rsp1_err),    32'(m_err[1]));
    endtask

    // One clock: inputs already set at the preceding negedge; compare at the next negedge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input int n, input int addr, input bit we, input logic [31:0] data);
        a_addr[n] = 3'(addr);
        a_we[n]   = we;
        a_data[n] = data;
        a_sync[n] = 1'b1;
    endtask

    task automatic idle();
        a_sync[0] = 1'b0;
        a_sync[1] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            a_addr[n] = '0; a_we[n] = 1'b0; a_data[n] = '0;
            a_sync[n] = 1'b0; r_sync[n] = 1'b1;
        end
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Write then read through requester 0
        issue(0, 2, 1'b1, 32'h1234_5678);
        cyc();
        idle();
        cyc();
        check("wr_old_val", rsp0_out, 32'h0);
        check("wr_rsp_valid", 32'(rsp0_notify), 32'd1);
        cyc();
        issue(0, 2, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();
        check("rd_back", rsp0_out, 32'h1234_5678);
        cyc();

        // Asynchronous reset with both requests pending
        issue(0, 1, 1'b1, 32'h55);
        issue(1, 0, 1'b1, 32'h66);
        cyc();
        idle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_req0_notify", 32'(req0_notify), 32'd1);
        check("rst_req1_notify", 32'(req1_notify), 32'd1);
        check("rst_rsp0_notify", 32'(rsp0_notify), 32'd0);
        check("rst_rsp1_notify", 32'(rsp1_notify), 32'd0);
        check("rst_rsp0_out",    rsp0_out,          32'd0);
        check("rst_rsp1_err",    32'(rsp1_err),     32'd0);
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Simultaneous issue after reset: requester 0 wins, requester 1 sees its write
        issue(0, 4, 1'b1, 32'd7);
        issue(1, 4, 1'b0, 32'd0);
        cyc();
        idle();
        cyc();
        check("cont_first_rsp0", 32'(rsp0_notify), 32'd1);
        check("cont_first_rsp1", 32'(rsp1_notify), 32'd0);
        cyc();
        check("cont_read7", rsp1_out, 32'd7);
        cyc();

        // Array cleared by reset
        issue(0, 3, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();
        check("rst_read3", rsp0_out, 32'd0);
        cyc();

        // Last grant went to requester 0, so requester 1 now has priority
        issue(0, 1, 1'b0, 32'h0);
        issue(1, 2, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();
        check("rr_pri_rsp1", 32'(rsp1_notify), 32'd1);
        check("rr_pri_rsp0", 32'(rsp0_notify), 32'd0);
        cyc();
        cyc();

        // Backpressure on response port 1 while requester 0 keeps running
        r_sync[1] = 1'b0;
        issue(1, 4, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();
        for (int t = 0; t < 2; t++) begin
            issue(0, t, 1'b1, 32'(t + 10));
            cyc();
            idle();
            cyc();
            cyc();
            check("bp_hold_out", rsp1_out, 32'd7);
            check("bp_hold_vld", 32'(rsp1_notify), 32'd1);
            check("bp_req1_busy", 32'(req1_notify), 32'd0);
        end
        r_sync[1] = 1'b1;
        cyc();

        // Out-of-range write leaves the array alone
        issue(0, 6, 1'b1, 32'd99);
        cyc();
        idle();
        cyc();
        check("oor_out", rsp0_out, 32'hFFFF_FFFF);
        check("oor_err", 32'(rsp0_err), 32'd1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            issue(0, i, 1'b0, 32'h0);
            cyc();
            idle();
            cyc();
            check("post_oor_read", rsp0_out, m_mem[i]);
            cyc();
        end

        // Long random run with random handshake timing
        for (int k = 0; k < 4000; k++) begin
            for (int n = 0; n < 2; n++) begin
                a_sync[n] = ($urandom_range(0, 1) == 1);
                a_addr[n] = 3'($urandom_range(0, 7));
                a_we[n]   = ($urandom_range(0, 1) == 1);
                a_data[n] = $urandom;
                r_sync[n] = ($urandom_range(0, 9) < 7);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
